// File: rtl/fpu_arbiter.sv
// Round-robin arbiter sharing one FPU between NUM_REQ requesters.
// Each requester sees a private op/operand/exec/done handshake; operations are serialised onto the FPU.
module fpu_arbiter #(
    parameter int NUM_REQ = 3
) (
    input  logic                       clk,
    input  logic                       reset_i,
    input  logic [NUM_REQ-1:0][3:0]    req_op_i,
    input  logic [NUM_REQ-1:0][31:0]   req_a_value_i,
    input  logic [NUM_REQ-1:0][31:0]   req_b_value_i,
    input  logic [NUM_REQ-1:0]         req_exec_strobe_i,
    output logic [31:0]                req_z_value_o,
    output logic [NUM_REQ-1:0]         req_done_strobe_o,
    output logic [3:0]                 fpu_op_o,
    output logic [31:0]                fpu_a_value_o,
    output logic [31:0]                fpu_b_value_o,
    output logic                       fpu_exec_strobe_o,
    input  logic [31:0]                fpu_z_value_i,
    input  logic                       fpu_done_strobe_i,
    output logic                       busy_o,
    output logic [NUM_REQ-1:0]         overrun_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    // Handshake: exec and done are single-cycle strobes with no back-pressure; a requester
    // may strobe again from the cycle after its done pulse, earlier strobes are flagged as overrun.
    state_t                      state_q, state_d;
    logic [NUM_REQ-1:0]          pend_q;
    logic [NUM_REQ-1:0][3:0]     slot_op_q;
    logic [NUM_REQ-1:0][31:0]    slot_a_q;
    logic [NUM_REQ-1:0][31:0]    slot_b_q;
    logic [IDX_W-1:0]            owner_q;
    logic [IDX_W-1:0]            last_grant_q;
    logic [IDX_W-1:0]            win_idx;
    logic [IDX_W-1:0]            cand;
    logic                        win_found;
    logic                        issue;
    logic                        finish;
    logic [NUM_REQ-1:0]          in_flight;
    logic [NUM_REQ-1:0]          capture;

    assign busy_o = (state_q == S_WAIT);

    always_comb begin
        in_flight = '0;
        capture   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            in_flight[i] = (state_q == S_WAIT) && (owner_q == IDX_W'(i));
            capture[i]   = req_exec_strobe_i[i] && !pend_q[i] && !in_flight[i];
        end
    end

    // Search starts just past the last served slot, so that slot is considered last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_grant_q) + k) % NUM_REQ);
            if (!win_found && pend_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        finish  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    issue   = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fpu_done_strobe_i) begin
                    finish  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            pend_q            <= '0;
            slot_op_q         <= '0;
            slot_a_q          <= '0;
            slot_b_q          <= '0;
            owner_q           <= '0;
            last_grant_q      <= IDX_W'(NUM_REQ - 1);
            fpu_op_o          <= '0;
            fpu_a_value_o     <= '0;
            fpu_b_value_o     <= '0;
            fpu_exec_strobe_o <= 1'b0;
            req_z_value_o     <= '0;
            req_done_strobe_o <= '0;
            overrun_o         <= '0;
        end else begin
            fpu_exec_strobe_o <= issue;
            req_done_strobe_o <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (capture[i]) begin
                    pend_q[i]    <= 1'b1;
                    slot_op_q[i] <= req_op_i[i];
                    slot_a_q[i]  <= req_a_value_i[i];
                    slot_b_q[i]  <= req_b_value_i[i];
                end else if (req_exec_strobe_i[i]) begin
                    overrun_o[i] <= 1'b1;
                end
            end
            // A captured slot is never the issuing one: capture needs pend clear, issue needs it set.
            if (issue) begin
                pend_q[win_idx] <= 1'b0;
                fpu_op_o        <= slot_op_q[win_idx];
                fpu_a_value_o   <= slot_a_q[win_idx];
                fpu_b_value_o   <= slot_b_q[win_idx];
                owner_q         <= win_idx;
            end
            if (finish) begin
                req_z_value_o              <= fpu_z_value_i;
                req_done_strobe_o[owner_q] <= 1'b1;
                last_grant_q               <= owner_q;
            end
        end
    end

endmodule

// File: tb/tb_fpu_arbiter.sv
// Self-checking bench for fpu_arbiter: directed vector table, corner-case sequences,
// and randomized traffic against a transaction-level arbitration model with an FPU model.
module tb_fpu_arbiter;

    localparam int N = 3;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_MUL = 4'd3;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic [N-1:0][3:0]    req_op_i;
    logic [N-1:0][31:0]   req_a_value_i;
    logic [N-1:0][31:0]   req_b_value_i;
    logic [N-1:0]         req_exec_strobe_i;
    logic [31:0]          req_z_value_o;
    logic [N-1:0]         req_done_strobe_o;
    logic [3:0]           fpu_op_o;
    logic [31:0]          fpu_a_value_o;
    logic [31:0]          fpu_b_value_o;
    logic                 fpu_exec_strobe_o;
    logic [31:0]          fpu_z_value_i;
    logic                 fpu_done_strobe_i;
    logic                 busy_o;
    logic [N-1:0]         overrun_o;

    fpu_arbiter #(.NUM_REQ(N)) dut (
        .clk               (clk),
        .reset_i           (reset_i),
        .req_op_i          (req_op_i),
        .req_a_value_i     (req_a_value_i),
        .req_b_value_i     (req_b_value_i),
        .req_exec_strobe_i (req_exec_strobe_i),
        .req_z_value_o     (req_z_value_o),
        .req_done_strobe_o (req_done_strobe_o),
        .fpu_op_o          (fpu_op_o),
        .fpu_a_value_o     (fpu_a_value_o),
        .fpu_b_value_o     (fpu_b_value_o),
        .fpu_exec_strobe_o (fpu_exec_strobe_o),
        .fpu_z_value_i     (fpu_z_value_i),
        .fpu_done_strobe_i (fpu_done_strobe_i),
        .busy_o            (busy_o),
        .overrun_o         (overrun_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int fpu_lat  = 4;
    int exec_cnt = 0;
    int done_cnt = 0;
    logic [31:0] a_log[$];
    int          exec_cyc_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- FPU arithmetic model ----------------
    function automatic real sp2r(input logic [31:0] s);
        logic [63:0] d;
        if (s[30:0] == 31'd0) return 0.0;
        d = {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2sp(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpu_model(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] b);
        if (op == OP_ADD) return r2sp(sp2r(a) + sp2r(b));
        if (op == OP_MUL) return r2sp(sp2r(a) * sp2r(b));
        return a ^ {b[15:0], b[31:16]} ^ {28'd0, op};
    endfunction

    // ---------------- shared FPU with programmable latency ----------------
    int          f_rem = 0;
    logic [3:0]  f_op;
    logic [31:0] f_a, f_b;
    initial begin
        fpu_done_strobe_i = 1'b0;
        fpu_z_value_i     = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            fpu_done_strobe_i = 1'b0;
            if (fpu_exec_strobe_o) begin
                exec_cnt++;
                a_log.push_back(fpu_a_value_o);
                exec_cyc_q.push_back(cyc);
                chk("fpu_no_overlap", 32'(f_rem), 32'd0);
                f_op  = fpu_op_o;
                f_a   = fpu_a_value_o;
                f_b   = fpu_b_value_o;
                f_rem = fpu_lat;
            end
            if (f_rem > 0) begin
                f_rem--;
                if (f_rem == 0) begin
                    fpu_done_strobe_i = 1'b1;
                    fpu_z_value_i     = fpu_model(f_op, f_a, f_b);
                end
            end
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [N-1:0]  m_pend, m_ovr, pre_pend;
    logic [3:0]    m_op[N];
    logic [31:0]   m_a[N], m_b[N];
    bit            m_busy, pre_busy;
    int            m_owner, m_last, pre_owner, w;
    logic [31:0]   exp_q[$];
    logic [N-1:0]  s_strb, e_done;
    logic [N-1:0][3:0]  s_op;
    logic [N-1:0][31:0] s_a, s_b;
    logic          s_fdone, e_exec;
    logic [3:0]    e_op;
    logic [31:0]   e_a, e_b, e_z;

    initial begin
        m_pend = '0; m_ovr = '0; m_busy = 0; m_owner = 0; m_last = N - 1;
        forever begin
            @(posedge clk);
            cyc++;
            s_strb = req_exec_strobe_i; s_op = req_op_i;
            s_a = req_a_value_i; s_b = req_b_value_i; s_fdone = fpu_done_strobe_i;
            if (reset_i) begin
                m_pend = '0; m_ovr = '0; m_busy = 0; m_owner = 0; m_last = N - 1;
                exp_q.delete();
            end else begin
                e_exec = 1'b0; e_done = '0; e_z = '0; e_op = '0; e_a = '0; e_b = '0;
                pre_pend = m_pend; pre_busy = m_busy; pre_owner = m_owner;
                if (pre_busy) begin
                    if (s_fdone) begin
                        e_done[m_owner] = 1'b1;
                        m_last = m_owner;
                        m_busy = 0;
                        if (exp_q.size() > 0) e_z = exp_q.pop_front();
                    end
                end else if (|m_pend) begin
                    w = -1;
                    for (int k = 1; k <= N; k++)
                        if (w < 0 && m_pend[(m_last + k) % N]) w = (m_last + k) % N;
                    e_exec = 1'b1; e_op = m_op[w]; e_a = m_a[w]; e_b = m_b[w];
                    m_pend[w] = 1'b0; m_busy = 1; m_owner = w;
                    exp_q.push_back(fpu_model(m_op[w], m_a[w], m_b[w]));
                end
                for (int i = 0; i < N; i++) begin
                    if (s_strb[i]) begin
                        if (pre_pend[i] || (pre_busy && pre_owner == i)) m_ovr[i] = 1'b1;
                        else begin
                            m_pend[i] = 1'b1; m_op[i] = s_op[i]; m_a[i] = s_a[i]; m_b[i] = s_b[i];
                        end
                    end
                end
                #1;
                chk("exec_strobe", 32'(fpu_exec_strobe_o), 32'(e_exec));
                if (e_exec) begin
                    chk("fpu_op", 32'(fpu_op_o), 32'(e_op));
                    chk("fpu_a", fpu_a_value_o, e_a);
                    chk("fpu_b", fpu_b_value_o, e_b);
                end
                chk("done_vec", 32'(req_done_strobe_o), 32'(e_done));
                if (|e_done) chk("result_z", req_z_value_o, e_z);
                if (|req_done_strobe_o) done_cnt++;
                chk("overrun", 32'(overrun_o), 32'(m_ovr));
                chk("busy", 32'(busy_o), 32'(m_busy));
            end
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        int          req;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] z;
    } vec_t;

    vec_t vecs[6];

    task automatic do_reset();
        @(negedge clk);
        reset_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
    endtask

    task automatic wait_done(output logic [N-1:0] dv, output logic [31:0] z, output int dcyc);
        dv = '0; z = '0; dcyc = -1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk);
            #1;
            if (|req_done_strobe_o) begin
                dv = req_done_strobe_o; z = req_z_value_o; dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic strobe_one(input int r, input logic [3:0] op, input logic [31:0] a,
                              input logic [31:0] b);
        @(negedge clk);
        req_op_i[r] = op; req_a_value_i[r] = a; req_b_value_i[r] = b;
        req_exec_strobe_i = N'(1) << r;
        @(negedge clk);
        req_exec_strobe_i = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int e0, dc;
        logic [N-1:0] dv;
        logic [31:0] z;
        e0 = exec_cnt;
        @(negedge clk);
        req_op_i[v.req] = v.op; req_a_value_i[v.req] = v.a; req_b_value_i[v.req] = v.b;
        req_exec_strobe_i = N'(1) << v.req;
        @(posedge clk);
        @(negedge clk);
        req_exec_strobe_i = '0;
        @(posedge clk);
        #1;
        chk("issue_latency", 32'(fpu_exec_strobe_o), 32'd1);
        wait_done(dv, z, dc);
        chk("vec_done_owner", 32'(dv), 32'(N'(1) << v.req));
        chk("vec_z", z, v.z);
        @(posedge clk);
        #1;
        chk("vec_done_one_cycle", 32'(req_done_strobe_o), 32'd0);
        chk("vec_single_exec", 32'(exec_cnt - e0), 32'd1);
    endtask

    task automatic wait_exec();
        bit seen;
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(posedge clk);
            #1;
            if (fpu_exec_strobe_o) seen = 1;
        end
        chk("exec_seen", 32'(seen), 32'd1);
    endtask

    // ---------------- test sequence ----------------
    logic [N-1:0] dvs[3];
    logic [31:0]  zs[3];
    int           dcs[3];
    logic [31:0]  sim_a[3];
    logic [31:0]  sim_z[3];
    int           cnt[N], want[N];
    int           nd, g1, p1, j02, e0, d0, sent, n_ops;
    bit           s1;
    logic [N-1:0] outst;

    initial begin : main
        vecs[0] = '{1, OP_ADD, 32'h3F800000, 32'h40000000, 32'h40400000};
        vecs[1] = '{0, OP_MUL, 32'h40000000, 32'h40400000, 32'h40C00000};
        vecs[2] = '{2, OP_ADD, 32'h3F000000, 32'h3E800000, 32'h3F400000};
        vecs[3] = '{1, OP_MUL, 32'h3FC00000, 32'h40800000, 32'h40C00000};
        vecs[4] = '{0, OP_MUL, 32'hC0000000, 32'h40400000, 32'hC0C00000};
        vecs[5] = '{2, OP_ADD, 32'h41200000, 32'hC0800000, 32'h40C00000};
        sim_a = '{32'h40000000, 32'h3F000000, 32'h40400000};
        sim_z = '{32'h40C00000, 32'h40000000, 32'h41100000};

        reset_i = 1'b1;
        req_op_i = '0; req_a_value_i = '0; req_b_value_i = '0; req_exec_strobe_i = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_exec", 32'(fpu_exec_strobe_o), 32'd0);
        chk("rst_done", 32'(req_done_strobe_o), 32'd0);
        chk("rst_overrun", 32'(overrun_o), 32'd0);
        chk("rst_z", req_z_value_o, 32'd0);
        chk("rst_fpu_a", fpu_a_value_o, 32'd0);
        reset_i = 1'b0;

        // table-driven single operations, FPU latency 4
        fpu_lat = 4;
        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // simultaneous strobes: served 0,1,2 with one bubble between operations
        do_reset();
        a_log.delete(); exec_cyc_q.delete();
        @(negedge clk);
        for (int r = 0; r < N; r++) begin
            req_op_i[r] = OP_MUL; req_a_value_i[r] = sim_a[r];
        end
        req_b_value_i[0] = 32'h40400000;
        req_b_value_i[1] = 32'h40800000;
        req_b_value_i[2] = 32'h40400000;
        req_exec_strobe_i = '1;
        @(negedge clk);
        req_exec_strobe_i = '0;
        for (int k = 0; k < 3; k++) wait_done(dvs[k], zs[k], dcs[k]);
        chk("sim_exec_count", 32'(a_log.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            chk("sim_done_owner", 32'(dvs[k]), 32'(N'(1) << k));
            chk("sim_product", zs[k], sim_z[k]);
            if (k < a_log.size()) chk("sim_grant_order", a_log[k], sim_a[k]);
            if (k > 0 && k < exec_cyc_q.size())
                chk("sim_one_bubble", 32'(exec_cyc_q[k]), 32'(dcs[k-1] + 1));
        end

        // fairness: 0 and 2 re-strobe immediately after each done, 1 joins mid-sequence
        do_reset();
        a_log.delete();
        cnt = '{0, 0, 0}; want = '{1, 0, 1}; nd = 0; g1 = -1; s1 = 0;
        for (int t = 0; t < 800 && nd < 11; t++) begin
            @(negedge clk);
            req_exec_strobe_i = '0;
            for (int r = 0; r < N; r++) if (req_done_strobe_o[r]) begin want[r] = 1; nd++; end
            for (int r = 0; r < N; r += 2) begin
                if (want[r] != 0 && cnt[r] < 5) begin
                    req_op_i[r] = 4'd5; req_a_value_i[r] = {4'(r), 28'(cnt[r])};
                    req_b_value_i[r] = 32'(t);
                    req_exec_strobe_i[r] = 1'b1;
                    cnt[r]++; want[r] = 0;
                end
            end
            if (!s1 && nd == 4) begin
                req_op_i[1] = 4'd6; req_a_value_i[1] = {4'd1, 28'd0}; req_b_value_i[1] = 32'd7;
                req_exec_strobe_i[1] = 1'b1;
                g1 = a_log.size(); s1 = 1;
            end
        end
        @(negedge clk);
        req_exec_strobe_i = '0;
        chk("fair_done_count", 32'(nd), 32'd11);
        p1 = -1; j02 = 0;
        for (int k = 0; k < a_log.size(); k++) begin
            if (a_log[k][31:28] == 4'd1) p1 = k;
            else begin
                chk("fair_alternate", 32'(a_log[k][31:28]), 32'((j02 % 2 == 0) ? 0 : 2));
                j02++;
            end
        end
        chk("fair_r1_within_2", 32'(p1 >= g1 && p1 < g1 + 2), 32'd1);

        // overrun: second strobe while the first op is in flight is dropped
        do_reset();
        e0 = exec_cnt; d0 = done_cnt;
        strobe_one(0, OP_ADD, 32'h3F800000, 32'h40000000);
        wait_exec();
        strobe_one(0, OP_MUL, 32'h40000000, 32'h40400000);
        chk("ovr_flag_set", 32'(overrun_o), 32'd1);
        wait_done(dvs[0], zs[0], dcs[0]);
        chk("ovr_done_owner", 32'(dvs[0]), 32'd1);
        chk("ovr_first_op_z", zs[0], 32'h40400000);
        repeat (30) @(posedge clk);
        #1;
        chk("ovr_one_exec", 32'(exec_cnt - e0), 32'd1);
        chk("ovr_one_done", 32'(done_cnt - d0), 32'd1);
        chk("ovr_sticky", 32'(overrun_o), 32'd1);

        // asynchronous reset mid-WAIT with requester 2 pending
        fpu_lat = 20;
        strobe_one(0, OP_ADD, 32'h3F800000, 32'h3F800000);
        wait_exec();
        strobe_one(2, OP_MUL, 32'h40000000, 32'h40400000);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        #2;
        reset_i = 1'b1;
        #1;
        chk("arst_busy", 32'(busy_o), 32'd0);
        chk("arst_overrun", 32'(overrun_o), 32'd0);
        chk("arst_z", req_z_value_o, 32'd0);
        chk("arst_fpu_op", 32'(fpu_op_o), 32'd0);
        chk("arst_fpu_a", fpu_a_value_o, 32'd0);
        chk("arst_fpu_b", fpu_b_value_o, 32'd0);
        chk("arst_done", 32'(req_done_strobe_o), 32'd0);
        @(negedge clk);
        reset_i = 1'b0;
        e0 = exec_cnt; d0 = done_cnt;
        repeat (25) @(posedge clk);
        #1;
        chk("late_done_ignored", 32'(done_cnt - d0), 32'd0);
        chk("pend_cleared", 32'(exec_cnt - e0), 32'd0);
        run_vec('{1, OP_ADD, 32'h3F000000, 32'h3E800000, 32'h3F400000});

        // latency sweep with random back-to-back traffic
        for (int li = 0; li < 2; li++) begin
            fpu_lat = (li == 0) ? 1 : 20;
            n_ops = (li == 0) ? 40 : 12;
            outst = '0; sent = 0;
            for (int t = 0; t < 2000 && (sent < n_ops || outst != '0); t++) begin
                @(negedge clk);
                req_exec_strobe_i = '0;
                for (int r = 0; r < N; r++) begin
                    if (req_done_strobe_o[r]) outst[r] = 1'b0;
                    if (!outst[r] && sent < n_ops && $urandom_range(0, 1) == 1) begin
                        req_op_i[r] = 4'($urandom_range(4, 15));
                        req_a_value_i[r] = $urandom;
                        req_b_value_i[r] = $urandom;
                        req_exec_strobe_i[r] = 1'b1;
                        outst[r] = 1'b1;
                        sent++;
                    end
                end
            end
            @(negedge clk);
            req_exec_strobe_i = '0;
            chk("sweep_drained", 32'(outst), 32'd0);
            chk("sweep_sent", 32'(sent), 32'(n_ops));
        end

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        chk("final_overrun_clear", 32'(overrun_o), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
        $fatal(1);
    end

endmodule

// File: doc/fpu_arbiter.md
# fpu_arbiter

Shares one FPU instance between `NUM_REQ` requesters, such as several `edge_function` engines or other rasterizer setup FSMs. The shared FPU has an op / operand / exec-strobe / done-strobe handshake, and each requester port presents the same handshake. The block captures each requester's operation on its strobe, grants the FPU round-robin, forwards exactly one operation at a time, and routes the result and done strobe back to the owner. Requesters connect to this block unchanged, as if they owned a private FPU.

## Interface
- `NUM_REQ`, default 3: number of requester ports, range 2..8.
- `clk  in  1`: system clock.
- `reset_i  in  1`: reset, asynchronous, active-high.
- `req_op_i  in  [NUM_REQ][3:0]`: per-requester FPU opcode (`FPU_OP_*` from graphite.svh).
- `req_a_value_i  in  [NUM_REQ][31:0]`: per-requester operand A.
- `req_b_value_i  in  [NUM_REQ][31:0]`: per-requester operand B.
- `req_exec_strobe_i  in  [NUM_REQ]`: one-cycle request pulse per requester.
- `req_z_value_o  out  32`: last result, shared by all requesters; valid in the owner's done cycle and held afterwards.
- `req_done_strobe_o  out  [NUM_REQ]`: one-cycle completion pulse per requester; one-hot or zero.
- `fpu_op_o  out  4`: opcode to the shared FPU.
- `fpu_a_value_o  out  32`: operand A to the shared FPU.
- `fpu_b_value_o  out  32`: operand B to the shared FPU.
- `fpu_exec_strobe_o  out  1`: one-cycle start pulse to the FPU.
- `fpu_z_value_i  in  32`: FPU result.
- `fpu_done_strobe_i  in  1`: FPU completion pulse.
- `busy_o  out  1`: high while an FPU operation is in flight (state WAIT).
- `overrun_o  out  [NUM_REQ]`: sticky per-requester protocol-violation flag; cleared only by reset.

## Operation
- **Per-requester slot.**
  - Each slot holds `pend`, op, a and b.
  - When `req_exec_strobe_i[i]` is high, the slot is idle and requester i is not in flight: latch op, a and b, and set `pend[i]`.
  - When the strobe arrives while `pend[i]` is set or requester i is in flight: ignore the strobe, keep the original captured operation, and set `overrun_o[i]`.
- **IDLE state.**
  - If any `pend` bit is set, pick the winner round-robin.
  - The search starts at `last_grant+1` modulo `NUM_REQ` and takes the first pending slot.
  - Drive the winner's op, a and b onto the `fpu_*` outputs and pulse `fpu_exec_strobe_o`.
  - Clear `pend[winner]`, set `owner <= winner`, and go to WAIT.
- **WAIT state.**
  - `fpu_exec_strobe_o <= 0`.
  - On `fpu_done_strobe_i`: `req_z_value_o <= fpu_z_value_i`, `req_done_strobe_o[owner] <= 1` for one cycle, `last_grant <= owner`, return to IDLE.
- **Input gating.**
  - `fpu_done_strobe_i` in IDLE is ignored.
  - `fpu_*` outputs hold their last values between operations.
- **Edge cases.**
  - Requester i strobing in the same cycle its done pulse is issued is impossible, because that pulse is registered. A strobe in the cycle after the done pulse is legal and is captured.
  - Simultaneous strobes on all ports: all are captured in the same cycle and served in round-robin order.
- **Reset (asynchronous, any state, including mid-WAIT).**
  - State returns to IDLE, all `pend` bits clear, `last_grant = NUM_REQ-1` (requester 0 wins first).
  - `fpu_exec_strobe_o = 0`, `req_done_strobe_o = 0`, `busy_o = 0`, `overrun_o = 0`.
  - `req_z_value_o = 0` and `fpu_op_o`/`fpu_a_value_o`/`fpu_b_value_o = 0`.
  - An FPU done arriving after reset is ignored, because the state is IDLE.

## Timing
- **Capture:** a strobe sampled at edge k sets `pend` after edge k.
- **Issue:** at edge k+1, IDLE issues; `fpu_exec_strobe_o` is high for the cycle after edge k+1. The request-to-FPU-strobe latency is 1 cycle.
- **Result:** an FPU done sampled at edge d gives `req_done_strobe_o[owner]` and a valid `req_z_value_o` after edge d.
- **Back-to-back issue:** the next grant issues at edge d+1, so there is one bubble cycle between consecutive operations.
- **Throughput:** one operation per (FPU latency + 2) cycles.
- **Arbitration latency:**
  - Worst case for a pending requester is `NUM_REQ-1` operations ahead of it.
  - No starvation: a slot that was just served is searched last.

## Test plan
- **Single request:** requester 1 strobes ADD with a=0x3F800000 and b=0x40000000; the FPU model has a 4-cycle latency.
  - `fpu_exec_strobe_o` pulses once, 1 cycle after the request.
  - `req_done_strobe_o` = 3'b010 for one cycle, with `req_z_value_o` = 0x40400000.
- **Simultaneous:** all 3 requesters strobe in the same cycle with distinct MULTIPLY operands.
  - The FPU sees operations in order 0, 1, 2, with one bubble between each.
  - Each done goes only to its owner, carrying the correct product (e.g. 2.0*3.0 = 0x40C00000).
- **Fairness:** requesters 0 and 2 re-strobe immediately after each done, for 10 operations.
  - Grants alternate 0, 2, 0, 2, …
  - Requester 1 strobes mid-sequence and is served within 2 operations.
- **Overrun:** requester 0 strobes again while its first operation is in flight, with different operands.
  - `overrun_o[0]` = 1 and stays set.
  - Only the first operation executes; one done pulse is produced.
- **Reset mid-WAIT:** assert `reset_i` asynchronously (between edges) while the FPU is busy and requester 2 is pending.
  - Outputs go to 0 immediately and `pend` clears.
  - A late `fpu_done_strobe_i` produces no `req_done_strobe_o`.
  - The next request is served normally.
- **Latency sweep:** FPU latency of 1 and 20 cycles with random back-to-back traffic.
  - The scoreboard matches every result to its requester.
  - There are never two `fpu_exec_strobe_o` pulses without an intervening done.
